// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM with branch redirect; FETCH_MISALIGN_CHECK_EN enables misaligned-redirect halt.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t      state, n_state;
  logic [31:0] fetch_pc, n_pc, req_pc, n_req_pc, n_inst, n_inst_pc, tgt;
  logic        kill, n_kill, halt, n_halt, n_iv, bad, good;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad = br_taken & (|br_target[1:0]);
  assign tgt = br_target;
`else
  assign bad = 1'b0;
  assign tgt = br_target & ~32'h3;
`endif
  assign good = br_taken & ~bad;
  // next-state and datapath selection; a redirect outranks every other transition
  always_comb begin
    n_state   = state;
    n_pc      = fetch_pc;
    n_req_pc  = req_pc;
    n_kill    = kill;
    n_halt    = halt;
    n_iv      = inst_valid;
    n_inst    = inst;
    n_inst_pc = inst_pc;
    case (state)
      IDLE: begin
        if (good) begin
          n_pc    = tgt;
          n_halt  = 1'b0;
          n_state = REQ;
        end else if (bad) n_halt = 1'b1;
        else if (!halt) n_state = REQ;
      end
      REQ: begin
        if (imem_gnt) n_req_pc = fetch_pc;
        if (br_taken) begin
          n_pc    = good ? tgt : fetch_pc;
          n_kill  = imem_gnt;
          n_halt  = bad;
          n_state = imem_gnt ? WAIT : (good ? REQ : IDLE);
        end else if (imem_gnt) begin
          n_pc    = fetch_pc + 32'd4;
          n_state = WAIT;
        end
      end
      WAIT: begin
        if (br_taken) begin
          n_pc    = good ? tgt : fetch_pc;
          n_kill  = ~imem_rvalid;
          n_halt  = bad;
          n_state = imem_rvalid ? (good ? REQ : IDLE) : WAIT;
        end else if (imem_rvalid && kill) begin
          n_kill  = 1'b0;
          n_state = halt ? IDLE : REQ;
        end else if (imem_rvalid) begin
          n_iv      = 1'b1;
          n_inst    = imem_rdata;
          n_inst_pc = req_pc;
          n_state   = HOLD;
        end
      end
      HOLD: begin
        if (br_taken) begin
          n_pc    = good ? tgt : fetch_pc;
          n_iv    = 1'b0;
          n_halt  = bad;
          n_state = good ? REQ : IDLE;
        end else if (!stall) begin
          n_iv    = 1'b0;
          n_state = REQ;
        end
      end
      default: n_state = IDLE;
    endcase
  end
  // state and registered outputs; the request port is driven from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      req_pc     <= '0;
      kill       <= 1'b0;
      halt       <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      misalign   <= 1'b0;
    end else begin
      state      <= n_state;
      fetch_pc   <= n_pc;
      req_pc     <= n_req_pc;
      kill       <= n_kill;
      halt       <= n_halt;
      imem_req   <= n_state == REQ;
      imem_addr  <= n_state == REQ ? n_pc : '0;
      inst_valid <= n_iv;
      inst       <= n_inst;
      inst_pc    <= n_inst_pc;
      misalign   <= bad;
    end
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 br_taken  input  1  redirect request from execute.
REQ-005 br_target  input  32  redirect address, valid with br_taken.
REQ-006 stall  input  1  decode cannot accept the presented instruction.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address, valid with imem_req.
REQ-009 imem_gnt  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid  input  1  read data valid.
REQ-011 imem_rdata  input  32  read data.
REQ-012 inst_valid  output  1  instruction presented to decode.
REQ-013 inst  output  32  instruction word.
REQ-014 inst_pc  output  32  address of inst.
REQ-015 misalign  output  1  misaligned redirect flag; constant 0 without FETCH_MISALIGN_CHECK_EN.

Function
REQ-016 Shall implement states IDLE, REQ, WAIT, HOLD with at most one outstanding memory request.
REQ-017 IDLE: imem_req=0; shall move to REQ next cycle unless halted per REQ-029.
REQ-018 REQ: imem_req=1, imem_addr=fetch_pc; on imem_gnt shall record req_pc=fetch_pc, set fetch_pc=fetch_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) and move to WAIT; else hold request and address stable.
REQ-019 WAIT: imem_req=0; on imem_rvalid with kill=0 shall register inst=imem_rdata, inst_pc=req_pc, move to HOLD; inst_valid=1 from the following cycle.
REQ-020 WAIT with kill=1: imem_rvalid shall discard the data, clear kill, move to REQ; inst_valid stays 0.
REQ-021 HOLD: inst_valid=1, inst/inst_pc stable while stall=1; with stall=0 the instruction is consumed that cycle and state moves to REQ.
REQ-022 br_taken shall have priority over stall and over all state transitions; fetch_pc=br_target from the next cycle.
REQ-023 br_taken in REQ without imem_gnt: next state REQ with new address; no request issued for old address.
REQ-024 br_taken in REQ with imem_gnt same cycle: next state WAIT, kill=1, fetch_pc=br_target (not +4).
REQ-025 br_taken in WAIT: kill=1, stay WAIT; if imem_rvalid same cycle, data discarded, kill stays 0, next state REQ.
REQ-026 br_taken in HOLD: held instruction dropped, inst_valid=0 next cycle, next state REQ.
REQ-027 imem_rvalid outside WAIT shall be ignored.

Reset
REQ-028 On reset: state=IDLE, fetch_pc=RESET_PC, req_pc=0, kill=0, imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, misalign=0; reset overrides br_taken and imem_rvalid in the same cycle, including mid-WAIT (late data after reset shall be ignored per REQ-027).

Configuration
REQ-029 With FETCH_MISALIGN_CHECK_EN defined: br_taken with br_target[1:0]!=0 shall pulse misalign for exactly one cycle (next cycle), leave fetch_pc unchanged, drop any held instruction, set kill if in WAIT, and halt in IDLE until an aligned br_taken; an aligned br_taken while halted loads br_target and moves to REQ.
REQ-030 Without FETCH_MISALIGN_CHECK_EN: br_target[1:0] shall be forced to 2'b00 when loaded; misalign tied 0; no halt.

Verification
REQ-031 Reset, gnt=1 each REQ, rvalid one cycle after gnt, stall=0 -> requests at 0x0, 0x4, 0x8; inst_pc follows; inst_valid one cycle per fetch.
REQ-032 stall=1 for 5 cycles in HOLD with inst=0x00500093 at 0x4 -> inst/inst_pc stable 5 cycles, no imem_req until stall falls.
REQ-033 br_taken to 0x100 in WAIT for 0x8, rvalid 2 cycles later -> data discarded, next imem_addr=0x100, no inst_valid for 0x8.
REQ-034 br_taken to 0x200 coincident with imem_gnt for 0xC -> response for 0xC discarded, next request 0x200.
REQ-035 RESET_PC=0xFFFF_FFFC -> first request 0xFFFF_FFFC, second 0x0.
REQ-036 Macro defined, br_taken target 0x102 -> misalign pulses once, IDLE halt; then br_taken 0x300 -> request 0x300. Macro undefined, same target -> request 0x100.
